// File: rtl/piso_shift_register.sv
// piso_shift_register: parallel-in, serial-out transmitter with frame markers.
// Accepts a WIDTH-bit word over a ready/valid load port and presents it one
// bit per enabled clock. A word offered on the last bit of the current frame
// starts the next frame on the following edge, so back-to-back words have no gap.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   load_valid_i   load_data_i holds a word to send
//   load_data_i    word to serialize, sampled on an accepted load
//   load_ready_o   a word can be accepted this cycle (combinational)
//   shift_en_i     advance enable; 0 stalls the serial stream
//   ser_out_o      current serial bit
//   ser_valid_o    ser_out_o carries a frame bit
//   frame_start_o  ser_out_o is the first bit of a frame
//   frame_last_o   ser_out_o is the last bit of a frame
//   done_o         one-cycle pulse after a final bit is consumed with no follow-on word
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             load_ready_o,
  input  logic             shift_en_i,
  output logic             ser_out_o,
  output logic             ser_valid_o,
  output logic             frame_start_o,
  output logic             frame_last_o,
  output logic             done_o
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  // Index whose increment lands on the final bit of the frame.
  localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(WIDTH - 2);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_valid_q, ser_valid_d;
  logic               frame_start_q, frame_start_d;
  logic               frame_last_q, frame_last_d;
  logic               done_q, done_d;

  logic               load_ready_c;
  logic               accept_c;
  logic               load_bit_c;
  logic [WIDTH-1:0]   load_rest_c;
  logic               shift_bit_c;
  logic [WIDTH-1:0]   shift_rest_c;

  // Ready in IDLE, or when the last bit is being consumed this edge.
  assign load_ready_c = rst_n & ((state_q == IDLE) |
                                 ((state_q == SHIFT) & frame_last_q & shift_en_i));
  assign accept_c     = load_valid_i & load_ready_c;

  // The first bit goes straight to ser_out; the register keeps the remainder
  // aligned so the next bit always sits at the output end.
  assign load_bit_c   = LSB_FIRST ? load_data_i[0] : load_data_i[WIDTH-1];
  assign load_rest_c  = LSB_FIRST ? (load_data_i >> 1) : (load_data_i << 1);
  assign shift_bit_c  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign shift_rest_c = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      idx_q         <= '0;
      ser_out_q     <= 1'b0;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_last_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      idx_q         <= idx_d;
      ser_out_q     <= ser_out_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_last_q  <= frame_last_d;
      done_q        <= done_d;
    end
  end

  // Next-state and output logic; everything holds unless an edge advances it.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    idx_d         = idx_q;
    ser_out_d     = ser_out_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    frame_last_d  = frame_last_q;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d       = SHIFT;
          shreg_d       = load_rest_c;
          idx_d         = '0;
          ser_out_d     = load_bit_c;
          ser_valid_d   = 1'b1;
          frame_start_d = 1'b1;
          frame_last_d  = 1'b0;
        end
      end

      SHIFT: begin
        if (shift_en_i) begin
          if (frame_last_q) begin
            if (accept_c) begin
              // Follow-on word: start the next frame with no gap cycle.
              shreg_d       = load_rest_c;
              idx_d         = '0;
              ser_out_d     = load_bit_c;
              ser_valid_d   = 1'b1;
              frame_start_d = 1'b1;
              frame_last_d  = 1'b0;
            end else begin
              state_d       = IDLE;
              shreg_d       = '0;
              idx_d         = '0;
              ser_out_d     = 1'b0;
              ser_valid_d   = 1'b0;
              frame_start_d = 1'b0;
              frame_last_d  = 1'b0;
              done_d        = 1'b1;
            end
          end else begin
            idx_d         = idx_q + IDX_W'(1);
            shreg_d       = shift_rest_c;
            ser_out_d     = shift_bit_c;
            frame_start_d = 1'b0;
            frame_last_d  = (idx_q == IDX_PENULT);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign load_ready_o  = load_ready_c;
  assign ser_out_o     = ser_out_q;
  assign ser_valid_o   = ser_valid_q;
  assign frame_start_o = frame_start_q;
  assign frame_last_o  = frame_last_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: an LSB-first instance checked against a
// scoreboard of expected (bit, start, last) tuples, plus an MSB-first instance
// checked with a directed sequence.
module tb_piso_shift_register;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         lv, en;
  logic [W-1:0] ld;
  logic         rdy, so, sv, fs, fl, dn;

  logic         lv2, en2;
  logic [W-1:0] ld2;
  logic         rdy2, so2, sv2, fs2, fl2, dn2;

  int           errors = 0;
  int           checks = 0;
  logic [2:0]   sb_q[$];
  logic [2:0]   sb_e;
  logic         exp_done = 1'b0;
  int           acc_cnt = 0;
  int           run_len = 0;
  int           last_run = 0;
  int           max_run = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(lv), .load_data_i(ld), .load_ready_o(rdy),
    .shift_en_i(en), .ser_out_o(so), .ser_valid_o(sv),
    .frame_start_o(fs), .frame_last_o(fl), .done_o(dn)
  );

  piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(lv2), .load_data_i(ld2), .load_ready_o(rdy2),
    .shift_en_i(en2), .ser_out_o(so2), .ser_valid_o(sv2),
    .frame_start_o(fs2), .frame_last_o(fl2), .done_o(dn2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word and hold it until the monitor sees it accepted.
  task automatic load_word(input logic [W-1:0] d);
    int start;
    start = acc_cnt;
    lv = 1'b1;
    ld = d;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc_cnt != start) break;
    end
    lv = 1'b0;
    chk("load_accept", 32'(acc_cnt - start), 32'd1);
  endtask

  // Monitor on the falling edge: compare the bit on display, then predict
  // what the next rising edge does (consume, accept, done).
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      exp_done = 1'b0;
      run_len  = 0;
    end else begin
      chk("done", 32'(dn), 32'(exp_done));
      chk("load_ready", 32'(rdy), 32'(!sv || (fl && en)));
      chk("start_last_excl", 32'(fs & fl), 32'd0);
      if (sv) begin
        run_len++;
        chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          if (en) begin
            sb_e = sb_q.pop_front();
            chk("ser_bit", 32'({so, fs, fl}), 32'(sb_e));
          end else begin
            chk("stall_hold", 32'({so, fs, fl}), 32'(sb_q[0]));
          end
        end
      end else begin
        chk("idle_out", 32'({so, fs, fl}), 32'd0);
        if (run_len > 0) begin
          last_run = run_len;
          if (run_len > max_run) max_run = run_len;
          run_len = 0;
        end
      end
      exp_done = sv && en && fl && !(lv && rdy);
      if (lv && rdy) begin
        acc_cnt++;
        for (int i = 0; i < W; i++) begin
          sb_q.push_back({ld[i], 1'(i == 0), 1'(i == W - 1)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] mw;
    int           c;
    lv = 1'b0; en = 1'b0; ld = '0;
    lv2 = 1'b0; en2 = 1'b0; ld2 = '0;

    // Reset state while held in reset.
    #8;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_outs", 32'({so, sv, fs, fl, dn}), 32'd0);
    #4;
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", 32'(rdy), 32'd1);

    // LSB-first single frame.
    en = 1'b1;
    load_word(8'h1E);
    repeat (12) step();

    // MSB-first single frame, directed edge-by-edge.
    mw  = 8'h1E;
    lv2 = 1'b1; ld2 = mw; en2 = 1'b1;
    step();
    lv2 = 1'b0;
    for (int e = 0; e < W; e++) begin
      chk("msb_frame", 32'({so2, fs2, fl2, sv2}),
          32'({mw[W-1-e], 1'(e == 0), 1'(e == W - 1), 1'b1}));
      step();
    end
    chk("msb_done", 32'({dn2, sv2}), 32'b10);
    step();
    chk("msb_done_pulse", 32'({dn2, sv2}), 32'b00);

    // Back-to-back frames.
    max_run = 0;
    load_word(8'hA5);
    load_word(8'h3C);
    repeat (12) step();
    chk("b2b_run", 32'(max_run), 32'd16);

    // Stall at index 3 and on the last bit.
    load_word(8'h96);
    repeat (3) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (4) step();
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    repeat (6) step();
    chk("stall_len", 32'(last_run), 32'd14);

    // Load pulse while busy is ignored.
    load_word(8'h5A);
    repeat (2) step();
    c  = acc_cnt;
    lv = 1'b1; ld = 8'hFF;
    step();
    lv = 1'b0;
    chk("ignored_load", 32'(acc_cnt), 32'(c));
    repeat (10) step();

    // Asynchronous reset mid-frame.
    load_word(8'hC3);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outs", 32'({so, sv, fs, fl, dn}), 32'd0);
    chk("arst_ready", 32'(rdy), 32'd0);
    @(posedge clk);
    #3;
    chk("arst_hold", 32'({so, sv, fs, fl, dn, rdy}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("arst_release_ready", 32'(rdy), 32'd1);
    step();
    load_word(8'h81);
    repeat (12) step();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
